// File: rtl/m_areg_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : m_areg_arbiter_if
// Purpose  : Bundles the request, memory-completion and access-register
//            signals that the arbiter sits between.
// Modports :
//   slave  - arbiter view (requests and mem_done_access in, grants and
//            access-register load out)
//   master - environment view (requesters and memory side)
// Signals  :
//   i_flits_req / v_i_flits_req  instruction-side flit and valid
//   d_flits_req / v_d_flits_req  data-side flit and valid
//   mem_done_access              memory finished the current access
//   i_req_ack / d_req_ack        one-cycle accept pulses
//   i_done / d_done              one-cycle completion pulses
//   m_areg_flits / v_m_areg_flits  access-register flit and load strobe
//   mem_src                      owner of current/last access (0=i, 1=d)
//   arb_busy                     high while an access is outstanding
//   timeout_err                  sticky memory-timeout flag
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface m_areg_arbiter_if #(
  parameter int FLIT_W = 48
);
  logic [FLIT_W-1:0] i_flits_req;
  logic              v_i_flits_req;
  logic [FLIT_W-1:0] d_flits_req;
  logic              v_d_flits_req;
  logic              mem_done_access;
  logic              i_req_ack;
  logic              d_req_ack;
  logic              i_done;
  logic              d_done;
  logic [FLIT_W-1:0] m_areg_flits;
  logic              v_m_areg_flits;
  logic              mem_src;
  logic              arb_busy;
  logic              timeout_err;

  modport slave (
    input  i_flits_req, v_i_flits_req, d_flits_req, v_d_flits_req,
           mem_done_access,
    output i_req_ack, d_req_ack, i_done, d_done, m_areg_flits,
           v_m_areg_flits, mem_src, arb_busy, timeout_err
  );

  modport master (
    output i_flits_req, v_i_flits_req, d_flits_req, v_d_flits_req,
           mem_done_access,
    input  i_req_ack, d_req_ack, i_done, d_done, m_areg_flits,
           v_m_areg_flits, mem_src, arb_busy, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/m_areg_arbiter.sv
//------------------------------------------------------------------------------
// Module   : m_areg_arbiter
// Purpose  : Round-robin arbiter between the instruction-side and data-side
//            request streams for the single memory access register. Loads the
//            winning flit with a one-cycle strobe, then holds busy until memory
//            reports completion or the timeout expires.
// Ports    :
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - m_areg_arbiter_if.slave (requests, acks, dones, access register,
//          mem_done_access, mem_src, arb_busy, timeout_err)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_areg_arbiter #(
  parameter int FLIT_W  = 48,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  m_areg_arbiter_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Last counter value that still counts as waiting; reaching it without a
  // done aborts the access.
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;          // 0 = i has priority, 1 = d
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [FLIT_W-1:0] flits_q, flits_d;
  logic              src_q, src_d;
  logic              vld_q, vld_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              terr_q, terr_d;

  // Pointer side wins when it is valid, otherwise whichever side is valid.
  logic              w_win;
  assign w_win = ptr_q ? bus.v_d_flits_req : ~bus.v_i_flits_req;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    flits_d  = flits_q;
    src_d    = src_q;
    terr_d   = terr_q;
    vld_d    = 1'b0;
    i_ack_d  = 1'b0;
    d_ack_d  = 1'b0;
    i_done_d = 1'b0;
    d_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.v_i_flits_req || bus.v_d_flits_req) begin
          flits_d = w_win ? bus.d_flits_req : bus.i_flits_req;
          src_d   = w_win;
          vld_d   = 1'b1;
          i_ack_d = ~w_win;
          d_ack_d = w_win;
          ptr_d   = ~w_win;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_done_access) begin
          i_done_d = ~src_q;
          d_done_d = src_q;
          state_d  = ST_IDLE;
        end else if (cnt_q == C_TO_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      flits_q  <= '0;
      src_q    <= 1'b0;
      vld_q    <= 1'b0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      flits_q  <= flits_d;
      src_q    <= src_d;
      vld_q    <= vld_d;
      i_ack_q  <= i_ack_d;
      d_ack_q  <= d_ack_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.i_req_ack      = i_ack_q;
  assign bus.d_req_ack      = d_ack_q;
  assign bus.i_done         = i_done_q;
  assign bus.d_done         = d_done_q;
  assign bus.m_areg_flits   = flits_q;
  assign bus.v_m_areg_flits = vld_q;
  assign bus.mem_src        = src_q;
  assign bus.arb_busy       = (state_q == ST_WAIT);
  assign bus.timeout_err    = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_m_areg_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_m_areg_arbiter
// Purpose  : Directed self-checking bench for m_areg_arbiter (TIMEOUT = 5).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_m_areg_arbiter;

  localparam int C_FLIT_W  = 48;
  localparam int C_TIMEOUT = 5;
  localparam int C_TO_W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  m_areg_arbiter_if #(.FLIT_W(C_FLIT_W)) bus ();

  m_areg_arbiter #(
    .FLIT_W  (C_FLIT_W),
    .TIMEOUT (C_TIMEOUT),
    .TO_W    (C_TO_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled at this edge,
  // outputs read after the call reflect it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic ia, input logic da,
                            input logic id, input logic dd, input logic v);
    chk({tag, ".i_ack"},  bus.i_req_ack,      ia);
    chk({tag, ".d_ack"},  bus.d_req_ack,      da);
    chk({tag, ".i_done"}, bus.i_done,         id);
    chk({tag, ".d_done"}, bus.d_done,         dd);
    chk({tag, ".strobe"}, bus.v_m_areg_flits, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] fa, fb;
    logic        exp_src;
    bus.i_flits_req     = '0;
    bus.v_i_flits_req   = 1'b0;
    bus.d_flits_req     = '0;
    bus.v_d_flits_req   = 1'b0;
    bus.mem_done_access = 1'b0;

    // Reset state
    tick(); tick();
    chk_pulses("reset", 0, 0, 0, 0, 0);
    chk("reset.flits", bus.m_areg_flits, 0);
    chk("reset.src",   bus.mem_src, 0);
    chk("reset.busy",  bus.arb_busy, 0);
    chk("reset.terr",  bus.timeout_err, 0);
    rst = 1'b0;
    tick();

    // Single i request, done after a few WAIT cycles
    bus.i_flits_req   = 48'h0000_1234_5678;
    bus.v_i_flits_req = 1'b1;
    tick();
    chk_pulses("single.grant", 1, 0, 0, 0, 1);
    chk("single.flits", bus.m_areg_flits, 48'h0000_1234_5678);
    chk("single.src",   bus.mem_src, 0);
    chk("single.busy",  bus.arb_busy, 1);
    bus.v_i_flits_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_pulses("single.wait", 0, 0, 0, 0, 0);
      chk("single.wait.busy", bus.arb_busy, 1);
    end
    bus.mem_done_access = 1'b1;
    tick();
    chk_pulses("single.done", 0, 0, 1, 0, 0);
    chk("single.done.busy", bus.arb_busy, 0);
    bus.mem_done_access = 1'b0;
    tick();
    chk_pulses("single.after", 0, 0, 0, 0, 0);

    // Spurious done in IDLE
    bus.mem_done_access = 1'b1;
    tick(); tick();
    chk_pulses("spurious", 0, 0, 0, 0, 0);
    chk("spurious.busy",  bus.arb_busy, 0);
    chk("spurious.flits", bus.m_areg_flits, 48'h0000_1234_5678);
    chk("spurious.src",   bus.mem_src, 0);
    bus.mem_done_access = 1'b0;

    // Contention from reset: i, d, i, d
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fa = 48'hAAAA_0000_0001;
    fb = 48'hBBBB_0000_0002;
    bus.i_flits_req   = fa;
    bus.d_flits_req   = fb;
    bus.v_i_flits_req = 1'b1;
    bus.v_d_flits_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_src = k[0];
      tick();
      chk_pulses("contend.grant", !exp_src, exp_src, 0, 0, 1);
      chk("contend.src",   bus.mem_src, exp_src);
      chk("contend.flits", bus.m_areg_flits, exp_src ? fb : fa);
      tick();
      chk_pulses("contend.wait", 0, 0, 0, 0, 0);
      bus.mem_done_access = 1'b1;
      tick();
      chk_pulses("contend.done", 0, 0, !exp_src, exp_src, 0);
      bus.mem_done_access = 1'b0;
    end
    bus.v_i_flits_req = 1'b0;
    bus.v_d_flits_req = 1'b0;
    tick();
    chk_pulses("contend.idle", 0, 0, 0, 0, 0);

    // Immediate done in the strobe cycle, back-to-back grant
    bus.d_flits_req   = 48'hCCCC_1111_2222;
    bus.v_d_flits_req = 1'b1;
    tick();
    chk_pulses("imm.grant", 0, 1, 0, 0, 1);
    bus.v_d_flits_req   = 1'b0;
    bus.mem_done_access = 1'b1;
    bus.i_flits_req     = 48'h0123_4567_89AB;
    bus.v_i_flits_req   = 1'b1;
    tick();
    chk_pulses("imm.done", 0, 0, 0, 1, 0);
    chk("imm.done.busy", bus.arb_busy, 0);
    bus.mem_done_access = 1'b0;
    tick();
    chk_pulses("imm.regrant", 1, 0, 0, 0, 1);
    chk("imm.regrant.flits", bus.m_areg_flits, 48'h0123_4567_89AB);
    bus.v_i_flits_req   = 1'b0;
    bus.mem_done_access = 1'b1;
    tick();
    chk_pulses("imm.done2", 0, 0, 1, 0, 0);
    bus.mem_done_access = 1'b0;
    tick();

    // Timeout on a d access
    bus.d_flits_req   = 48'hDDDD_DDDD_0005;
    bus.v_d_flits_req = 1'b1;
    tick();
    chk_pulses("to.grant", 0, 1, 0, 0, 1);
    bus.v_d_flits_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("to.wait.terr", bus.timeout_err, 0);
      chk("to.wait.busy", bus.arb_busy, 1);
    end
    tick();
    chk("to.terr",  bus.timeout_err, 1);
    chk("to.busy",  bus.arb_busy, 0);
    chk_pulses("to.abort", 0, 0, 0, 0, 0);
    chk("to.flits", bus.m_areg_flits, 48'hDDDD_DDDD_0005);
    chk("to.src",   bus.mem_src, 1);
    tick();
    chk("to.nodone", bus.d_done, 0);
    bus.v_i_flits_req = 1'b1;
    tick();
    chk_pulses("to.next.grant", 1, 0, 0, 0, 1);
    bus.v_i_flits_req   = 1'b0;
    bus.mem_done_access = 1'b1;
    tick();
    chk_pulses("to.next.done", 0, 0, 1, 0, 0);
    chk("to.sticky", bus.timeout_err, 1);
    bus.mem_done_access = 1'b0;
    tick();

    // Reset mid-WAIT after an i grant (pointer left on d)
    bus.i_flits_req   = 48'hEEEE_0000_EEEE;
    bus.v_i_flits_req = 1'b1;
    tick();
    chk_pulses("rstw.grant", 1, 0, 0, 0, 1);
    bus.v_i_flits_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_pulses("rstw.reset", 0, 0, 0, 0, 0);
    chk("rstw.flits", bus.m_areg_flits, 0);
    chk("rstw.src",   bus.mem_src, 0);
    chk("rstw.busy",  bus.arb_busy, 0);
    chk("rstw.terr",  bus.timeout_err, 0);
    bus.mem_done_access = 1'b1;
    tick();
    chk_pulses("rstw.nodone", 0, 0, 0, 0, 0);
    bus.mem_done_access = 1'b0;
    bus.d_flits_req   = 48'hFFFF_0000_FFFF;
    bus.v_i_flits_req = 1'b1;
    bus.v_d_flits_req = 1'b1;
    tick();
    chk_pulses("rstw.ptr", 1, 0, 0, 0, 1);
    chk("rstw.ptr.src", bus.mem_src, 0);
    bus.v_i_flits_req = 1'b0;
    bus.v_d_flits_req = 1'b0;
    bus.mem_done_access = 1'b1;
    tick();
    bus.mem_done_access = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/m_areg_arbiter.md
Name: m_areg_arbiter

Overview:
- Arbitrates between the instruction-side and data-side request streams for the single memory access register that feeds memory.
- Grants one requester at a time, round-robin. Loads the winning 48-bit flit with a one-cycle valid pulse, then holds the register busy until mem_done_access.
- Returns per-requester ack (accepted) and done (completed) pulses. Flags a sticky timeout error if memory never completes.

Parameters:
- FLIT_W, 48, flit width.
- TIMEOUT, 255, WAIT cycles allowed before abort; range 1..2^TO_W-1.
- TO_W, 8, timeout counter width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_flits_req  input  FLIT_W  instruction-side request flit
- v_i_flits_req  input  1  instruction-side request valid; held until i_req_ack
- d_flits_req  input  FLIT_W  data-side request flit
- v_d_flits_req  input  1  data-side request valid; held until d_req_ack
- mem_done_access  input  1  memory finished current access (level or pulse)
- i_req_ack  output  1  one-cycle pulse: i request accepted
- d_req_ack  output  1  one-cycle pulse: d request accepted
- i_done  output  1  one-cycle pulse: i access completed
- d_done  output  1  one-cycle pulse: d access completed
- m_areg_flits  output  FLIT_W  flit to access register
- v_m_areg_flits  output  1  one-cycle load strobe for access register
- mem_src  output  1  owner of current/last access: 0=i, 1=d
- arb_busy  output  1  high while state is WAIT
- timeout_err  output  1  sticky; cleared only by rst

Behaviour:
- Single clock domain. Synchronous active-high reset. All outputs registered.
- Reset values: all outputs 0, m_areg_flits 0. State IDLE, priority pointer = i, counter 0.
- FSM states: IDLE, WAIT.
- IDLE, sampled at edge N:
  - If either valid is high, pick a winner. The pointer side wins if it is valid; otherwise the other valid side wins.
  - At edge N: m_areg_flits <= winner flit; mem_src <= winner; v_m_areg_flits <= 1; winner ack <= 1; pointer <= non-winner; counter <= 0; state <= WAIT.
  - Result: ack and strobe are visible in cycle N+1, one-cycle latency from a sampled request.
  - If no valid is high, stay in IDLE.
- WAIT:
  - v_m_areg_flits and ack pulses are 0 after their single cycle. arb_busy = 1.
  - Both request valids are ignored. Requests stay pending at the requester.
  - Each cycle without mem_done_access: counter increments.
  - mem_done_access sampled high: done pulse for mem_src next cycle; state <= IDLE. This includes the first WAIT cycle, the same cycle as the strobe.
  - Counter reaching TIMEOUT with no done: timeout_err <= 1; state <= IDLE; no done pulse. m_areg_flits and mem_src keep their values.
- mem_done_access while in IDLE is ignored.
- m_areg_flits and mem_src hold their value until the next grant.
- Requester protocol:
  - Deassert valid in the cycle after seeing ack, or present the next flit.
  - A valid still high in IDLE after completion is treated as a new request.
  - A valid dropped before grant is not served.
- Fairness: the pointer toggles on every grant, so back-to-back contention alternates i, d, i, d.
- Earliest new grant: edge after returning to IDLE. Minimum access cycle is 3 clocks (IDLE, WAIT, IDLE).
- Reset mid-WAIT: immediate return to reset values. No done pulse; pending access discarded; timeout_err cleared.
- Done pulse never coincides with an ack pulse for the same requester.

Test Plan:
- Single request: after reset, v_i_flits_req=1, i_flits_req=48'h0000_1234_5678.
  - Cycle+1: i_req_ack=1, v_m_areg_flits=1, m_areg_flits=48'h0000_1234_5678, mem_src=0, arb_busy=1.
  - Done 4 cycles later: i_done pulses once; arb_busy=0.
- Contention: both valids high from reset, mem_done_access asserted 2 cycles after each strobe, valids held throughout.
  - Grant order i, d, i, d; mem_src toggles 0,1,0,1.
  - Each ack paired with exactly one matching done pulse.
- Timeout: TIMEOUT=5, d request, mem_done_access held 0.
  - timeout_err=1 exactly 5 WAIT cycles after strobe; no d_done; state back to IDLE.
  - timeout_err stays 1 through later successful accesses.
- Spurious done: mem_done_access=1 in IDLE with no requests.
  - No done pulses; outputs unchanged.
- Immediate done: mem_done_access high in the strobe cycle.
  - done pulse the next cycle; a new request is granted the cycle after that.
- Reset mid-WAIT: rst pulsed 2 cycles after strobe.
  - All outputs 0 next cycle; no done pulse.
  - Subsequent simultaneous requests grant i first (pointer reset).
